mult_arbiter: RTL and testbench
===============================

MULT_ARBITER -- requirements
Module: mult_arbiter

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits; product width is 2*WIDTH.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req0_valid  input  1  requester 0 has an operand pair.
REQ-005 req0_a, req0_b  input  WIDTH each  requester 0 operands, unsigned.
REQ-006 req0_ready  output  1  requester 0 accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  same as REQ-004..006, for requester 1.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_product  output  2*WIDTH  unsigned product.
REQ-010 rsp_id  output  1  requester that owns the result (0 or 1).
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 FSM states SHALL be IDLE, CALC and DONE.
REQ-014 In IDLE, grant: only one valid -> that requester; both valid -> requester named by the priority pointer; none valid -> no grant.
REQ-015 reqX_ready SHALL be combinational: high only in IDLE, only for the granted requester, and never for both requesters at once.
REQ-016 Acceptance happens on an edge where reqX_valid && reqX_ready: latch a, b and id; clear the accumulator and step counter; go to CALC; set the pointer to the other requester.
REQ-017 Operands are sampled only at acceptance; later changes on req inputs SHALL have no effect.
REQ-018 CALC SHALL run exactly WIDTH cycles of shift-add, one multiplier bit per edge, LSB first.
- On each step, when the bit is 1, acc += a shifted left by the step index.
- The product is computed at full 2*WIDTH width with no overflow.
REQ-019 After the WIDTH-th CALC edge, go to DONE; rsp_valid rises in the cycle after that edge.
- Latency: WIDTH+1 edges from the acceptance edge to the first cycle with rsp_valid high.
REQ-020 In DONE, rsp_valid, rsp_product and rsp_id SHALL be held stable until an edge where rsp_ready is high; that edge returns the FSM to IDLE.
REQ-021 No request is accepted outside IDLE; back-to-back throughput is one operation per WIDTH+2 cycles with rsp_ready high.
REQ-022 rsp_product and rsp_id are valid only while rsp_valid is high; they SHALL hold their last value otherwise.
REQ-023 Zero operands SHALL take the same latency as any other operands; the all-ones case gives (2^WIDTH-1)^2.
REQ-024 rsp_ready asserted while not in DONE SHALL be ignored.

Reset
REQ-025 While rst is high, and immediately on assertion, the block SHALL:
- go to IDLE;
- drive rsp_valid=0, rsp_product=0, rsp_id=0 and busy=0;
- set the priority pointer to 0;
- clear the accumulator, counter and latched operands.
REQ-026 Reset during CALC or DONE SHALL abort the operation with no response; the first request after reset is arbitrated from a fresh state.
REQ-027 reqX_ready SHALL be 0 while rst is high.

Verification (WIDTH=4)
REQ-028 Single request: req0 only, a=6, b=6 -> req0_ready high at acceptance; rsp_valid 5 edges later; product=8'h24, rsp_id=0.
REQ-029 Simultaneous requests after reset: req0 (7,5) and req1 (7,7) both valid -> req0 served first (8'h23, id 0), then req1 (8'h31, id 1); ready never high for both.
REQ-030 Backpressure: rsp_ready low for 3 cycles in DONE -> rsp_valid, product and id stable; busy=1; no reqX_ready; completes on the first rsp_ready edge.
REQ-031 Round-robin: both requesters continuously valid, rsp_ready=1 -> grants alternate 0,1,0,1; one operation per 6 cycles.
REQ-032 Boundaries: 15x15 -> 8'hE1; 0x9 -> 8'h00, both with the 5-edge latency; 2x6 -> 8'h0C.
REQ-033 Reset mid-CALC: rst pulsed after the 2nd CALC edge -> all outputs 0 at once; no response; the next req1-only request is accepted and gives the correct product.

Source files
------------

// File: rtl/mult_arbiter.sv
// Two-requester shift-add multiplier with round-robin arbitration.
// One operation in flight; results are held until the consumer accepts them.
module mult_arbiter #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req0_valid,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  output logic               req0_ready,
  input  logic               req1_valid,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               req1_ready,
  output logic               rsp_valid,
  output logic [2*WIDTH-1:0] rsp_product,
  output logic               rsp_id,
  input  logic               rsp_ready,
  output logic               busy
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_n;
  logic           ptr;
  logic [PW-1:0]  a_q;
  logic [WIDTH-1:0] b_q;
  logic           id_q;
  logic [PW-1:0]  acc;
  logic [PW-1:0]  acc_n;
  logic [CW-1:0]  cnt;
  logic [PW-1:0]  prod_q;
  logic           pid_q;
  logic           gnt0, gnt1;
  logic           take;
  logic           last;

  // Pointer only matters on a tie; a lone requester always wins.
  always_comb begin
    gnt0 = req0_valid & (~req1_valid | ~ptr);
    gnt1 = req1_valid & (~req0_valid | ptr);
    req0_ready = ~rst & (state == IDLE) & gnt0;
    req1_ready = ~rst & (state == IDLE) & gnt1;
    take = req0_ready | req1_ready;
    last = (cnt == LAST);
    acc_n = b_q[cnt] ? acc + (a_q << cnt) : acc;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (take) state_n = CALC;
      CALC:    if (last) state_n = DONE;
      DONE:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      id_q   <= 1'b0;
      acc    <= '0;
      cnt    <= '0;
      prod_q <= '0;
      pid_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (take) begin
          a_q  <= {{WIDTH{1'b0}}, (req1_ready ? req1_a : req0_a)};
          b_q  <= req1_ready ? req1_b : req0_b;
          id_q <= req1_ready;
          ptr  <= ~req1_ready;
          acc  <= '0;
          cnt  <= '0;
        end
        CALC: begin
          acc <= acc_n;
          cnt <= cnt + CW'(1);
          if (last) begin
            prod_q <= acc_n;
            pid_q  <= id_q;
          end
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid   = (state == DONE);
  assign rsp_product = prod_q;
  assign rsp_id      = pid_q;
  assign busy        = (state != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: transaction-level model, per-cycle compare,
// directed scenarios plus a randomized run.
module tb_mult_arbiter;

  localparam int W = 4;

  logic         clk = 0;
  logic         rst = 1;
  logic         v0 = 0, v1 = 0;
  logic [W-1:0] a0 = 0, b0 = 0, a1 = 0, b1 = 0;
  logic         r0, r1;
  logic         rsp_valid;
  logic [2*W-1:0] rsp_product;
  logic         rsp_id;
  logic         rsp_ready = 1;
  logic         busy;

  int cmp = 0;
  int bad = 0;

  mult_arbiter #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(v0), .req0_a(a0), .req0_b(b0), .req0_ready(r0),
    .req1_valid(v1), .req1_a(a1), .req1_b(b1), .req1_ready(r1),
    .rsp_valid(rsp_valid), .rsp_product(rsp_product),
    .rsp_id(rsp_id), .rsp_ready(rsp_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    cmp++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int grant(input logic x0, input logic x1,
                               input logic p);
    if (x0 && x1) return int'(p);
    if (x0) return 0;
    if (x1) return 1;
    return -1;
  endfunction

  // Model: phase 0 = waiting, 1 = multiplying, 2 = holding a result.
  int        m_ph = 0;
  int        m_left = 0;
  logic      m_ptr = 0;
  logic [7:0] m_a = 0, m_b = 0;
  logic      m_id = 0;
  logic [7:0] m_prod = 0;
  logic      m_pid = 0;
  int        cyc = 0;
  int        g;
  int        gnt_log[$];
  int        acc_cyc[$];
  logic [8:0] cpl_log[$];
  int        lat_log[$];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_ph   <= 0;
      m_ptr  <= 0;
      m_prod <= 0;
      m_pid  <= 0;
      m_left <= 0;
    end else begin
      cyc <= cyc + 1;
      case (m_ph)
        0: begin
          g = grant(v0, v1, m_ptr);
          if (g >= 0) begin
            m_ph   <= 1;
            m_left <= W;
            m_ptr  <= (g == 0);
            m_a    <= (g == 1) ? {4'd0, a1} : {4'd0, a0};
            m_b    <= (g == 1) ? {4'd0, b1} : {4'd0, b0};
            m_id   <= (g == 1);
            gnt_log.push_back(g);
            acc_cyc.push_back(cyc);
          end
        end
        1: begin
          if (m_left == 1) begin
            m_ph   <= 2;
            m_prod <= m_a * m_b;
            m_pid  <= m_id;
            cpl_log.push_back({m_id, 8'(m_a * m_b)});
            lat_log.push_back(cyc - acc_cyc[$] + 1);
          end else begin
            m_left <= m_left - 1;
          end
        end
        default: if (rsp_ready) m_ph <= 0;
      endcase
    end
  end

  int ex;
  always @(negedge clk) begin
    ex = (rst || m_ph != 0) ? -1 : grant(v0, v1, m_ptr);
    chk("req0_ready", 32'(r0), 32'(ex == 0));
    chk("req1_ready", 32'(r1), 32'(ex == 1));
    chk("rsp_valid", 32'(rsp_valid), 32'(m_ph == 2 && !rst));
    chk("busy", 32'(busy), 32'(m_ph != 0 && !rst));
    chk("rsp_product", 32'(rsp_product), 32'(rst ? 8'h00 : m_prod));
    chk("rsp_id", 32'(rsp_id), 32'(rst ? 1'b0 : m_pid));
  end

  task automatic req(input int port, input logic [W-1:0] a,
                     input logic [W-1:0] b);
    bit ok = 0;
    if (port == 0) begin v0 = 1; a0 = a; b0 = b; end
    else begin v1 = 1; a1 = a; b1 = b; end
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if ((port == 0) ? r0 : r1) ok = 1;
    end
    chk("accept_timeout", 32'(ok), 32'(1));
    @(posedge clk);
    #2;
    if (port == 0) begin v0 = 0; a0 = W'($urandom); b0 = W'($urandom); end
    else begin v1 = 0; a1 = W'($urandom); b1 = W'($urandom); end
  endtask

  task automatic wait_idle();
    bit ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (!busy) ok = 1;
    end
    chk("idle_timeout", 32'(ok), 32'(1));
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #2;
    rst = 1;
    @(posedge clk);
    #2;
    rst = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1);
  end

  initial begin
    bit d0, d1, s0, s1, ok;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_busy", 32'(busy), 32'(0));
    chk("reset_product", 32'(rsp_product), 32'(0));
    rst = 0;

    // Single request 6x6
    gnt_log.delete(); cpl_log.delete(); lat_log.delete();
    req(0, 6, 6);
    wait_idle();
    chk("single_prod", 32'(cpl_log[0]), 32'({1'b0, 8'h24}));
    chk("single_lat", lat_log[0], 5);

    // Simultaneous after reset
    pulse_rst();
    cpl_log.delete();
    v0 = 1; a0 = 7; b0 = 5; v1 = 1; a1 = 7; b1 = 7;
    d0 = 0; d1 = 0;
    for (int i = 0; i < 60 && !(d0 && d1); i++) begin
      @(negedge clk);
      s0 = r0; s1 = r1;
      if (s0 && s1) chk("both_ready", 32'(1), 32'(0));
      @(posedge clk);
      #2;
      if (s0) begin v0 = 0; d0 = 1; end
      if (s1) begin v1 = 0; d1 = 1; end
    end
    wait_idle();
    chk("sim_count", cpl_log.size(), 2);
    chk("sim_first", 32'(cpl_log[0]), 32'({1'b0, 8'h23}));
    chk("sim_second", 32'(cpl_log[1]), 32'({1'b1, 8'h31}));

    // Backpressure 2x6 on req1
    cpl_log.delete();
    rsp_ready = 0;
    req(1, 2, 6);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1;
    end
    chk("bp_timeout", 32'(ok), 32'(1));
    v0 = 1; a0 = 3; b0 = 3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 32'(1));
      chk("bp_prod", 32'(rsp_product), 32'(8'h0C));
      chk("bp_id", 32'(rsp_id), 32'(1));
      chk("bp_busy", 32'(busy), 32'(1));
      chk("bp_ready", 32'({r0, r1}), 32'(0));
    end
    v0 = 0;
    rsp_ready = 1;
    wait_idle();

    // Round-robin, both continuously valid
    gnt_log.delete(); acc_cyc.delete();
    v0 = 1; v1 = 1;
    for (int i = 0; i < 26; i++) begin
      @(posedge clk);
      #2;
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
    end
    v0 = 0; v1 = 0;
    wait_idle();
    chk("rr_count_ge4", 32'(gnt_log.size() >= 4), 32'(1));
    for (int i = 1; i < 4; i++) begin
      chk("rr_alt", gnt_log[i], 1 - gnt_log[i-1]);
      chk("rr_space", acc_cyc[i] - acc_cyc[i-1], 6);
    end

    // Boundaries
    cpl_log.delete(); lat_log.delete();
    req(0, 15, 15);
    wait_idle();
    req(1, 0, 9);
    wait_idle();
    chk("max_prod", 32'(cpl_log[0]), 32'({1'b0, 8'hE1}));
    chk("max_lat", lat_log[0], 5);
    chk("zero_prod", 32'(cpl_log[1]), 32'({1'b1, 8'h00}));
    chk("zero_lat", lat_log[1], 5);

    // Reset in the middle of CALC
    cpl_log.delete();
    req(0, 9, 9);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("mid_rst_valid", 32'(rsp_valid), 32'(0));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_prod", 32'(rsp_product), 32'(0));
    chk("mid_rst_id", 32'(rsp_id), 32'(0));
    @(posedge clk);
    #2;
    rst = 0;
    repeat (6) @(posedge clk);
    #2;
    chk("mid_rst_norsp", cpl_log.size(), 0);
    req(1, 3, 5);
    wait_idle();
    chk("after_rst", 32'(cpl_log[0]), 32'({1'b1, 8'h0F}));

    // Randomized traffic with random backpressure
    for (int i = 0; i < 400; i++) begin
      @(posedge clk);
      #2;
      v0 = 1'($urandom); v1 = 1'($urandom);
      a0 = W'($urandom); b0 = W'($urandom);
      a1 = W'($urandom); b1 = W'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    v0 = 0; v1 = 0; rsp_ready = 1;
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
